seq_divider: RTL and testbench

- Sequential restoring divider; the inverse operation of the calculator's combinational array multiplier.
- Takes an unsigned WIDTH-bit dividend and divisor and produces quotient and remainder.
- Resolves one quotient bit per clock; start/busy/done handshake toward the calculator control logic.
- Sits beside the multiplier in the arithmetic datapath; results are multiplexed onto the display path.

---
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a FIXUP cycle).
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
   typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
`else
   typedef enum logic {IDLE, CALC} state_t;
`endif

   state_t           state_reg;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] dvsr_reg;
   logic [WIDTH-1:0] prem_reg;
   logic [CW-1:0]    count_reg;
`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             neg_q_reg;
   logic             neg_r_reg;
`endif

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] prem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] dvd_in;
   logic [WIDTH-1:0] dvs_in;

   // Magnitudes feed the unsigned core; signs are reapplied in FIXUP.
   always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
      dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
      dvd_in = dividend;
      dvs_in = divisor;
`endif
   end

   // Trial subtraction; a set MSB of the difference means it went negative.
   always_comb begin
      shifted = {prem_reg, shift_reg[WIDTH-1]};
      diff    = shifted - {1'b0, dvsr_reg};
      if (!diff[WIDTH]) begin
         prem_next = diff[WIDTH-1:0];
         quo_next  = {shift_reg[WIDTH-2:0], 1'b1};
      end else begin
         prem_next = shifted[WIDTH-1:0];
         quo_next  = {shift_reg[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         dvsr_reg  <= '0;
         prem_reg  <= '0;
         count_reg <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     div_zero  <= 1'b1;
                     done      <= 1'b1;
                  end else begin
                     shift_reg <= dvd_in;
                     dvsr_reg  <= dvs_in;
                     prem_reg  <= '0;
                     count_reg <= '0;
                     busy      <= 1'b1;
                     state_reg <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                     neg_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     neg_r_reg <= dividend[WIDTH-1];
`endif
                  end
               end
            end
            CALC: begin
               prem_reg  <= prem_next;
               shift_reg <= quo_next;
               count_reg <= count_reg + 1'b1;
               if (count_reg == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                  state_reg <= FIXUP;
`else
                  quotient  <= quo_next;
                  remainder <= prem_next;
                  div_zero  <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_reg <= IDLE;
`endif
               end
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            FIXUP: begin
               quotient  <= neg_q_reg ? -shift_reg : shift_reg;
               remainder <= neg_r_reg ? -prem_reg  : prem_reg;
               div_zero  <= 1'b0;
               done      <= 1'b1;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider; reference model uses plain integer division.
module tb_seq_divider;

   localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = W;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_zero;

   int tests = 0;
   int fails = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   // Behavioural reference: integer division straight from the arithmetic rules.
   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic dz);
      int ia, ib, iq, ir;
      if (b == '0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         ia = int'($signed(a));
         ib = int'($signed(b));
`else
         ia = int'(a);
         ib = int'(b);
`endif
         iq = ia / ib;
         ir = ia % ib;
         q  = W'(iq);
         r  = W'(ir);
         dz = 1'b0;
      end
   endfunction

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts clock edges after acceptance until done, bounded.
   task automatic wait_done(output int cyc, output int bc);
      cyc = 0;
      bc  = 0;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({quotient, remainder, busy, done, div_zero} !== '0) begin
         fails++;
         $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dz=%b, want all 0",
                  quotient, remainder, busy, done, div_zero);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int n, bc;
      logic [W-1:0] eq, er;
      logic ez;
      ref_div(8'd200, 8'd7, eq, er, ez);
      launch(8'd200, 8'd7);
      wait_done(n, bc);
      $display("[TB] basic 200/7 -> q=%0d r=%0d dz=%0b edges=%0d", quotient, remainder, div_zero, n);
      tests++;
      if (n !== LAT) begin
         fails++;
         $display("FAIL basic_latency: got %0d, want %0d", n, LAT);
      end
      tests++;
      if (bc !== LAT) begin
         fails++;
         $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, LAT);
      end
      tests++;
      if ({quotient, remainder, div_zero} !== {eq, er, ez}) begin
         fails++;
         $display("FAIL basic_result: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                  quotient, remainder, div_zero, eq, er, ez);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || quotient !== eq) begin
         fails++;
         $display("FAIL basic_done_pulse: got done=%b q=%h, want done=0 q=%h", done, quotient, eq);
      end
   endtask

   task automatic test_div_zero();
      int n, bc;
      logic [W-1:0] eq, er;
      logic ez;
      launch(8'd5, 8'd0);
      wait_done(n, bc);
      $display("[TB] div_zero 5/0 -> q=%0d r=%0d dz=%0b edges=%0d", quotient, remainder, div_zero, n);
      tests++;
      if (n !== 0 || bc !== 0) begin
         fails++;
         $display("FAIL dz_timing: got edges=%0d busy=%0d, want 0 and 0", n, bc);
      end
      tests++;
      if ({quotient, remainder, div_zero} !== {8'hFF, 8'd5, 1'b1}) begin
         fails++;
         $display("FAIL dz_result: got q=%h r=%h dz=%b, want q=ff r=05 dz=1",
                  quotient, remainder, div_zero);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || div_zero !== 1'b1) begin
         fails++;
         $display("FAIL dz_hold: got done=%b dz=%b, want done=0 dz=1", done, div_zero);
      end
      ref_div(8'd9, 8'd3, eq, er, ez);
      launch(8'd9, 8'd3);
      wait_done(n, bc);
      $display("[TB] div_zero follow 9/3 -> q=%0d r=%0d dz=%0b", quotient, remainder, div_zero);
      tests++;
      if ({quotient, remainder, div_zero} !== {eq, er, ez} || n !== LAT) begin
         fails++;
         $display("FAIL dz_clear: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                  quotient, remainder, div_zero, n, eq, er, ez, LAT);
      end
   endtask

   task automatic test_edges();
      logic [W-1:0] aq[$];
      logic [W-1:0] bq[$];
      int n, bc;
      logic [W-1:0] eq, er;
      logic ez;
      aq = '{8'd255, 8'd3, 8'd0, 8'd255};
      bq = '{8'd1, 8'd10, 8'd9, 8'd255};
`ifdef SEQ_DIVIDER_SIGNED_EN
      aq.push_back(8'h9C); bq.push_back(8'd7);
      aq.push_back(8'h80); bq.push_back(8'hFF);
      aq.push_back(8'd100); bq.push_back(8'hF9);
`endif
      for (int i = 0; i < aq.size(); i++) begin
         ref_div(aq[i], bq[i], eq, er, ez);
         launch(aq[i], bq[i]);
         wait_done(n, bc);
         $display("[TB] edge %h/%h -> q=%h r=%h dz=%0b edges=%0d", aq[i], bq[i],
                  quotient, remainder, div_zero, n);
         tests++;
         if ({quotient, remainder, div_zero} !== {eq, er, ez} || n !== LAT) begin
            fails++;
            $display("FAIL edge_%0d: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                     i, quotient, remainder, div_zero, n, eq, er, ez, LAT);
         end
      end
   endtask

   task automatic test_back_to_back();
      int n, bc;
      logic [W-1:0] eq, er, eq2, er2;
      logic ez, ez2;
      ref_div(8'd100, 8'd9, eq, er, ez);
      ref_div(8'd50, 8'd5, eq2, er2, ez2);
      @(negedge clk);
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd9;
      @(negedge clk);
      dividend = 8'd50;
      divisor  = 8'd5;
      wait_done(n, bc);
      $display("[TB] b2b 100/9 (start held) -> q=%0d r=%0d edges=%0d", quotient, remainder, n);
      tests++;
      if ({quotient, remainder, div_zero} !== {eq, er, ez} || n !== LAT) begin
         fails++;
         $display("FAIL b2b_first: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                  quotient, remainder, div_zero, n, eq, er, ez, LAT);
      end
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || quotient !== eq) begin
         fails++;
         $display("FAIL b2b_accept: got busy=%b q=%h, want busy=1 q=%h", busy, quotient, eq);
      end
      wait_done(n, bc);
      $display("[TB] b2b 50/5 -> q=%0d r=%0d edges=%0d", quotient, remainder, n);
      tests++;
      if ({quotient, remainder, div_zero} !== {eq2, er2, ez2} || n !== LAT) begin
         fails++;
         $display("FAIL b2b_second: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                  quotient, remainder, div_zero, n, eq2, er2, ez2, LAT);
      end
   endtask

   task automatic test_reset_abort();
      int n, bc;
      logic saw_done;
      logic [W-1:0] eq, er;
      logic ez;
      launch(8'd200, 8'd7);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({quotient, remainder, busy, done, div_zero} !== '0) begin
         fails++;
         $display("FAIL abort_async: got q=%h r=%h busy=%b done=%b dz=%b, want all 0",
                  quotient, remainder, busy, done, div_zero);
      end
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (LAT + 2) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      tests++;
      if (saw_done !== 1'b0) begin
         fails++;
         $display("FAIL abort_no_done: got done pulse, want none");
      end
      ref_div(8'd100, 8'd9, eq, er, ez);
      launch(8'd100, 8'd9);
      wait_done(n, bc);
      $display("[TB] after abort 100/9 -> q=%0d r=%0d edges=%0d", quotient, remainder, n);
      tests++;
      if ({quotient, remainder, div_zero} !== {eq, er, ez} || n !== LAT) begin
         fails++;
         $display("FAIL abort_recover: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                  quotient, remainder, div_zero, n, eq, er, ez, LAT);
      end
   endtask

   task automatic test_random();
      int n, bc, elat;
      logic [W-1:0] a, b, eq, er;
      logic ez;
      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         ref_div(a, b, eq, er, ez);
         elat = (b == '0) ? 0 : LAT;
         launch(a, b);
         wait_done(n, bc);
         $display("[TB] rand %h/%h -> q=%h r=%h dz=%0b edges=%0d", a, b,
                  quotient, remainder, div_zero, n);
         tests++;
         if ({quotient, remainder, div_zero} !== {eq, er, ez} || n !== elat) begin
            fails++;
            $display("FAIL rand_%0d: got q=%h r=%h dz=%b edges=%0d, want q=%h r=%h dz=%b edges=%0d",
                     i, quotient, remainder, div_zero, n, eq, er, ez, elat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_edges();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
